// File: rtl/rgmii_pkg.sv
// Shared constants for the RGMII receive framer: FSM encoding, framing bytes and CRC-32 values.
package rgmii_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_PAYLOAD,
        ST_DROP
    } rx_state_e;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
    // Register value left after running the reflected CRC across data plus a correct FCS.
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc32_byte_update.sv
// Combinational reflected CRC-32 step: next register value from current value plus one byte.
// Only built when RGMII_RX_CRC_CHECK_EN is defined.
`ifdef RGMII_RX_CRC_CHECK_EN
module crc32_byte_update
    import rgmii_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    localparam logic [31:0] PolyRefl = reflect32(CRC32_POLY);

    always_comb begin
        crc_o = crc_i;
        // LSB-first shift matches the order bits travel on the wire.
        for (int i = 0; i < 8; i++) begin
            crc_o = (crc_o >> 1) ^ (((crc_o[0] ^ data_i[i]) == 1'b1) ? PolyRefl : 32'h0);
        end
    end

endmodule
`endif

// File: rtl/rgmii_rx_framer.sv
// RGMII receive framer: hunts preamble/SFD, forwards payload (FCS included), flags start/end/ok.
// Optional FCS checking is compiled in with RGMII_RX_CRC_CHECK_EN.
module rgmii_rx_framer
    import rgmii_pkg::*;
#(
    parameter int unsigned MIN_PREAMBLE  = 2,
    parameter int unsigned MAX_FRAME_LEN = 1522,
    parameter int unsigned LEN_W         = 11
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [7:0]       rx_data_i,
    input  logic             rx_dv_i,
    input  logic             rx_er_i,
    output logic [7:0]       data_o,
    output logic             data_valid_o,
    output logic             frame_start_o,
    output logic             frame_end_o,
    output logic             frame_ok_o,
    output logic [LEN_W-1:0] frame_length_o,
    output logic             active_o
);

    logic [7:0]       rx_data_q;
    logic             rx_dv_q, rx_er_q;
    rx_state_e        state_q, state_d;
    logic [3:0]       pre_cnt_q, pre_cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] len_hold_q, len_hold_d;
    logic             err_q, err_d;
    logic             crc_init, crc_adv, crc_good;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_data_q  <= '0;
            rx_dv_q    <= 1'b0;
            rx_er_q    <= 1'b0;
            state_q    <= ST_IDLE;
            pre_cnt_q  <= '0;
            len_q      <= '0;
            len_hold_q <= '0;
            err_q      <= 1'b0;
        end else begin
            rx_data_q  <= rx_data_i;
            rx_dv_q    <= rx_dv_i;
            rx_er_q    <= rx_er_i;
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            len_q      <= len_d;
            len_hold_q <= len_hold_d;
            err_q      <= err_d;
        end
    end

`ifdef RGMII_RX_CRC_CHECK_EN
    logic [31:0] crc_q, crc_next;

    crc32_byte_update u_crc (
        .crc_i  (crc_q),
        .data_i (rx_data_q),
        .crc_o  (crc_next)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crc_q <= CRC32_INIT;
        end else if (crc_init) begin
            crc_q <= CRC32_INIT;
        end else if (crc_adv) begin
            crc_q <= crc_next;
        end
    end

    assign crc_good = (crc_q == CRC32_RESIDUE) && (32'(len_q) >= 32'd4);
`else
    logic unused_crc;
    assign unused_crc = crc_init ^ crc_adv;
    assign crc_good   = 1'b1;
`endif

    always_comb begin
        state_d        = state_q;
        pre_cnt_d      = pre_cnt_q;
        len_d          = len_q;
        len_hold_d     = len_hold_q;
        err_d          = err_q;
        crc_init       = 1'b0;
        crc_adv        = 1'b0;
        data_o         = '0;
        data_valid_o   = 1'b0;
        frame_start_o  = 1'b0;
        frame_end_o    = 1'b0;
        frame_ok_o     = 1'b0;
        frame_length_o = len_hold_q;
        active_o       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rx_dv_q) begin
                    if (rx_data_q == PREAMBLE_BYTE) begin
                        pre_cnt_d = 4'd1;
                        state_d   = ST_PREAMBLE;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
            end
            ST_PREAMBLE: begin
                if (!rx_dv_q) begin
                    state_d = ST_IDLE;
                end else if (rx_data_q == PREAMBLE_BYTE) begin
                    if (pre_cnt_q != 4'hF) begin
                        pre_cnt_d = pre_cnt_q + 4'd1;
                    end
                end else if (rx_data_q == SFD_BYTE && 32'(pre_cnt_q) >= MIN_PREAMBLE) begin
                    state_d  = ST_PAYLOAD;
                    active_o = 1'b1;
                    len_d    = '0;
                    err_d    = 1'b0;
                    crc_init = 1'b1;
                end else begin
                    state_d = ST_DROP;
                end
            end
            ST_PAYLOAD: begin
                active_o = 1'b1;
                if (rx_dv_q) begin
                    if (32'(len_q) >= MAX_FRAME_LEN) begin
                        // Overlength: swallow this byte and close the frame as bad.
                        frame_end_o    = 1'b1;
                        frame_length_o = len_q;
                        len_hold_d     = len_q;
                        state_d        = ST_DROP;
                    end else begin
                        data_o        = rx_data_q;
                        data_valid_o  = 1'b1;
                        frame_start_o = (len_q == '0);
                        len_d         = len_q + 1'b1;
                        crc_adv       = 1'b1;
                        if (rx_er_q) begin
                            err_d = 1'b1;
                        end
                    end
                end else begin
                    frame_end_o    = 1'b1;
                    frame_ok_o     = !err_q && (len_q != '0) && crc_good;
                    frame_length_o = len_q;
                    len_hold_d     = len_q;
                    state_d        = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (!rx_dv_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_rgmii_rx_framer.sv
// Randomised self-checking bench for rgmii_rx_framer against a burst-level frame model.
module tb_rgmii_rx_framer;

    localparam int MINPRE = 2;
    localparam int MAXLEN = 1522;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_dv = 1'b0;
    logic        rx_er = 1'b0;
    logic [7:0]  data;
    logic        data_valid, frame_start, frame_end, frame_ok, active;
    logic [10:0] frame_length;

    rgmii_rx_framer #(
        .MIN_PREAMBLE  (MINPRE),
        .MAX_FRAME_LEN (MAXLEN),
        .LEN_W         (11)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .rx_data_i      (rx_data),
        .rx_dv_i        (rx_dv),
        .rx_er_i        (rx_er),
        .data_o         (data),
        .data_valid_o   (data_valid),
        .frame_start_o  (frame_start),
        .frame_end_o    (frame_end),
        .frame_ok_o     (frame_ok),
        .frame_length_o (frame_length),
        .active_o       (active)
    );

    always #4 clk = ~clk;

    typedef struct packed {logic er; logic [7:0] d;} cyc_t;
    typedef struct packed {logic ok; logic [10:0] len;} end_t;

    cyc_t        burst[$];
    logic [7:0]  exp_b[$], got_b[$];
    end_t        exp_e[$], got_e[$];
    int          exp_starts = 0, got_starts = 0;
    int          proto_err = 0, active_cycles = 0;
    int          tests = 0, fails = 0;
    int          gpb = 0, epb = 0, gpe = 0, epe = 0, gps = 0, eps = 0;

    // Protocol monitor: collects forwarded bytes and frame ends, flags framing violations.
    logic        prev_v = 1'b0;
    logic        holding = 1'b0;
    logic [10:0] hold_len = '0;
    always @(negedge clk) begin
        end_t e;
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (active) active_cycles++;
            if (data_valid) begin
                got_b.push_back(data);
                if (!active) proto_err++;
            end
            if (frame_start) begin
                got_starts++;
                if (!data_valid || prev_v) proto_err++;
                holding = 1'b0;
            end else if (data_valid && !prev_v) begin
                proto_err++;
            end
            if (frame_end) begin
                e.ok = frame_ok;
                e.len = frame_length;
                got_e.push_back(e);
                if (data_valid) proto_err++;
                holding = 1'b1;
                hold_len = frame_length;
            end else if (holding && frame_length !== hold_len) begin
                proto_err++;
            end
            prev_v = data_valid;
        end
    end

    task automatic check(input string tag, input int obs, input int expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] crc32(input logic [7:0] b[$]);
        logic [31:0] c = 32'hFFFF_FFFF;
        foreach (b[i]) begin
            c = c ^ {24'h0, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic bit fcs_ok(input logic [7:0] pl[$]);
        logic [7:0] body[$];
        int n = pl.size();
        if (n < 4) return 1'b0;
        for (int i = 0; i < n - 4; i++) body.push_back(pl[i]);
        return crc32(body) == {pl[n-1], pl[n-2], pl[n-3], pl[n-4]};
    endfunction

    task automatic push_cyc(input logic er, input logic [7:0] d);
        cyc_t x;
        x.er = er;
        x.d = d;
        burst.push_back(x);
    endtask

    task automatic build_frame(input int npre, input int nbody, input bit fcs);
        logic [7:0] body[$];
        logic [31:0] c;
        logic [7:0] b;
        burst.delete();
        for (int i = 0; i < npre; i++) push_cyc(1'b0, 8'h55);
        push_cyc(1'b0, 8'hD5);
        for (int i = 0; i < nbody; i++) begin
            b = 8'($urandom);
            body.push_back(b);
            push_cyc(1'b0, b);
        end
        if (fcs) begin
            c = crc32(body);
            for (int k = 0; k < 4; k++) push_cyc(1'b0, c[8*k +: 8]);
        end
    endtask

    // Expected outcome of one rx_dv burst, derived from the framing rules directly.
    task automatic model_burst();
        int n = 0;
        int plen;
        bit err = 1'b0;
        bit ok;
        logic [7:0] pl[$];
        end_t e;
        while (n < burst.size() && burst[n].d == 8'h55) n++;
        if (n == 0 || n >= burst.size()) return;
        if (burst[n].d != 8'hD5 || n < MINPRE) return;
        for (int i = n + 1; i < burst.size(); i++) begin
            pl.push_back(burst[i].d);
            err |= burst[i].er;
        end
        plen = pl.size();
        if (plen > MAXLEN) begin
            for (int i = 0; i < MAXLEN; i++) exp_b.push_back(pl[i]);
            exp_starts++;
            e.ok = 1'b0;
            e.len = 11'(MAXLEN);
            exp_e.push_back(e);
            return;
        end
        foreach (pl[i]) exp_b.push_back(pl[i]);
        if (plen > 0) exp_starts++;
        ok = !err && plen >= 1;
`ifdef RGMII_RX_CRC_CHECK_EN
        ok = ok && fcs_ok(pl);
`endif
        e.ok = ok;
        e.len = 11'(plen);
        exp_e.push_back(e);
    endtask

    task automatic drive_cyc(input logic dv, input logic er, input logic [7:0] d);
        @(negedge clk);
        rx_dv = dv;
        rx_er = er;
        rx_data = d;
    endtask

    task automatic run_burst(input int gap);
        foreach (burst[i]) drive_cyc(1'b1, burst[i].er, burst[i].d);
        for (int i = 0; i < gap; i++) drive_cyc(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
    endtask

    task automatic compare_all(input string tag);
        int mism = 0;
        int nb = got_b.size() - gpb;
        int ne = got_e.size() - gpe;
        drive_cyc(1'b0, 1'b0, 8'h00);
        drive_cyc(1'b0, 1'b0, 8'h00);
        drive_cyc(1'b0, 1'b0, 8'h00);
        nb = got_b.size() - gpb;
        ne = got_e.size() - gpe;
        check({tag, " byte count"}, nb, exp_b.size() - epb);
        for (int i = 0; i < nb && i < exp_b.size() - epb; i++)
            if (got_b[gpb+i] !== exp_b[epb+i]) mism++;
        check({tag, " byte mismatches"}, mism, 0);
        check({tag, " end count"}, ne, exp_e.size() - epe);
        for (int i = 0; i < ne && i < exp_e.size() - epe; i++) begin
            check({tag, " frame_ok"}, int'(got_e[gpe+i].ok), int'(exp_e[epe+i].ok));
            check({tag, " frame_length"}, int'(got_e[gpe+i].len), int'(exp_e[epe+i].len));
        end
        check({tag, " start count"}, got_starts - gps, exp_starts - eps);
        check({tag, " protocol errors"}, proto_err, 0);
        gpb = got_b.size(); epb = exp_b.size();
        gpe = got_e.size(); epe = exp_e.size();
        gps = got_starts;   eps = exp_starts;
    endtask

    initial begin
        int act0, gb, ge, gs;
        #20;
        check("reset outputs", int'({data, frame_length, data_valid, frame_start, frame_end,
                                     frame_ok, active}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_cyc(1'b0, 1'b1, 8'h55);
        drive_cyc(1'b0, 1'b0, 8'h00);

        // Good 64-byte frame with valid FCS.
        act0 = active_cycles;
        build_frame(7, 60, 1'b1);
        model_burst();
        run_burst(3);
        compare_all("good64");
        check("good64 active cycles", active_cycles - act0, 66);

        // rx_er on payload byte 20: still forwarded, frame bad.
        build_frame(7, 60, 1'b1);
        burst[8+19].er = 1'b1;
        model_burst();
        run_burst(2);
        compare_all("rxer");

        // Preamble too short.
        act0 = active_cycles;
        burst.delete();
        push_cyc(1'b0, 8'h55);
        push_cyc(1'b0, 8'hD5);
        for (int i = 0; i < 10; i++) push_cyc(1'b0, 8'($urandom));
        model_burst();
        run_burst(2);
        compare_all("shortpre");
        check("shortpre active cycles", active_cycles - act0, 0);

        // Overlength abort.
        build_frame(7, 1526, 1'b1);
        model_burst();
        run_burst(3);
        compare_all("overlen");

        // Back-to-back with a single idle cycle.
        build_frame(7, 60, 1'b1);
        model_burst();
        run_burst(1);
        build_frame(7, 60, 1'b1);
        model_burst();
        run_burst(3);
        compare_all("b2b");

        // Corrupted FCS bit.
        build_frame(7, 60, 1'b1);
        burst[burst.size()-1].d = burst[burst.size()-1].d ^ 8'h10;
        model_burst();
        run_burst(2);
        compare_all("fcsflip");

        // SFD immediately followed by rx_dv low.
        build_frame(3, 0, 1'b0);
        model_burst();
        run_burst(2);
        compare_all("emptyframe");

        // Randomised mix of good, bad, truncated and garbage bursts.
        for (int f = 0; f < 25; f++) begin
            int npre = $urandom_range(0, 9);
            build_frame(npre, $urandom_range(0, 80), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 4) == 0) burst[0].d = 8'($urandom);
            foreach (burst[i]) if ($urandom_range(0, 29) == 0) burst[i].er = 1'b1;
            if ($urandom_range(0, 5) == 0)
                while (burst.size() > 1 && burst.size() > npre / 2) void'(burst.pop_back());
            model_burst();
            run_burst($urandom_range(1, 4));
        end
        compare_all("random");

        // Asynchronous reset mid-payload; remainder of frame must be dropped.
        build_frame(7, 60, 1'b1);
        for (int i = 27; i < burst.size(); i++) if (burst[i].d == 8'h55) burst[i].d = 8'h56;
        for (int i = 0; i < 28; i++) drive_cyc(1'b1, burst[i].er, burst[i].d);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset outputs", int'({data, frame_length, data_valid, frame_start, frame_end,
                                        frame_ok, active}), 0);
        gb = got_b.size();
        ge = got_e.size();
        gs = got_starts;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 28; i < burst.size(); i++) drive_cyc(1'b1, burst[i].er, burst[i].d);
        for (int i = 0; i < 4; i++) drive_cyc(1'b0, 1'b0, 8'h00);
        check("midreset bytes after release", got_b.size() - gb, 0);
        check("midreset ends after release", got_e.size() - ge, 0);
        check("midreset starts after release", got_starts - gs, 0);
        gpb = got_b.size(); epb = exp_b.size();
        gpe = got_e.size(); epe = exp_e.size();
        gps = got_starts;   eps = exp_starts;

        build_frame(7, 60, 1'b1);
        model_burst();
        run_burst(3);
        compare_all("recovery");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
